ps2_key_tracker: RTL and testbench

- Consumes scan-code bytes from the existing ps2_keyboard receiver through its ready/nextdata_n FIFO handshake.
- Decodes set-2 prefixes: E0 marks an extended key, F0 marks a break.
- Emits one event per complete key action and keeps a parametrised set of currently held keys. Typematic repeats do not count as presses.
- Provides display code, held count and press counter for the seven-segment/ASCII front end, replacing the single-key show/close FSM.

---
 rtl/ps2_key_tracker.sv | 214 +++++++++++++++++++++
 tb/tb_ps2_key_tracker.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ps2_key_tracker : set-2 scan-code decoder with held-key tracking         |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module ps2_key_tracker #(
    parameter int HOLD_SLOTS = 4,
    parameter int CNT_W      = 8,
    parameter int HC_W       = $clog2(HOLD_SLOTS + 1)
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             rx_ready,
    input  logic [7:0]       rx_data,
    input  logic             rx_overflow,
    output logic             rx_nextdata_n,
    output logic             ev_valid,
    output logic [7:0]       ev_code,
    output logic             ev_ext,
    output logic             ev_break,
    output logic             ev_repeat,
    output logic [7:0]       disp_code,
    output logic             disp_ext,
    output logic [HC_W-1:0]  held_count,
    output logic             any_held,
    output logic [CNT_W-1:0] press_count,
    output logic             err_overflow,
    output logic             err_proto
);

    localparam int SLOT_W = (HOLD_SLOTS > 1) ? $clog2(HOLD_SLOTS) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_EXT     = 2'd1;
    localparam logic [1:0] S_BRK     = 2'd2;
    localparam logic [1:0] S_EXT_BRK = 2'd3;

    logic [1:0]            state_q, state_d;
    logic                  nextdata_n_q;
    logic                  ovf_reg_q, ovf_prev_q;
    logic                  err_ovf_q, err_proto_q;
    logic                  ev_valid_q, ev_ext_q, ev_break_q, ev_repeat_q;
    logic [7:0]            ev_code_q;
    logic [7:0]            disp_code_q;
    logic                  disp_ext_q;
    logic [CNT_W-1:0]      press_cnt_q;
    logic [HOLD_SLOTS-1:0] valid_q, valid_d;
    logic [8:0]            key_q [HOLD_SLOTS];
    logic [8:0]            key_d [HOLD_SLOTS];

    logic w_take, w_ovf_rise, w_byte_ok;
    logic w_is_e0, w_is_f0, w_is_bad;
    logic w_press, w_release, w_proto, w_ext;
    logic w_hit, w_free_found;
    logic [SLOT_W-1:0] w_hit_idx, w_free_idx;
    logic [HC_W-1:0]   w_held_cnt;

    // A take is only allowed while the pop strobe is idle, giving one byte per 2 cycles.
    assign w_take     = rx_ready & nextdata_n_q;
    assign w_ovf_rise = ovf_reg_q & ~ovf_prev_q;
    assign w_byte_ok  = w_take & ~w_ovf_rise;
    assign w_is_e0    = (rx_data == 8'hE0);
    assign w_is_f0    = (rx_data == 8'hF0);
    assign w_is_bad   = (rx_data == 8'h00) || (rx_data == 8'hFF);

    // FSM state register
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        if (w_ovf_rise) begin
            state_d = S_IDLE;
        end else if (w_take) begin
            case (state_q)
                S_IDLE: begin
                    if (w_is_e0)      state_d = S_EXT;
                    else if (w_is_f0) state_d = S_BRK;
                end
                S_EXT: begin
                    if (w_is_f0)      state_d = S_EXT_BRK;
                    else if (!w_is_e0) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FSM output decode
    always_comb begin
        w_press   = 1'b0;
        w_release = 1'b0;
        w_proto   = 1'b0;
        w_ext     = 1'b0;
        if (w_byte_ok) begin
            case (state_q)
                S_IDLE: begin
                    if (w_is_bad)                 w_proto = 1'b1;
                    else if (!w_is_e0 && !w_is_f0) w_press = 1'b1;
                end
                S_EXT: begin
                    w_ext = 1'b1;
                    if (w_is_bad)                 w_proto = 1'b1;
                    else if (!w_is_e0 && !w_is_f0) w_press = 1'b1;
                end
                default: begin
                    w_ext = (state_q == S_EXT_BRK);
                    if (w_is_bad || w_is_e0 || w_is_f0) w_proto   = 1'b1;
                    else                                w_release = 1'b1;
                end
            endcase
        end
    end

    // Slot lookup: descending scan so the lowest matching/free index wins.
    always_comb begin
        w_hit        = 1'b0;
        w_hit_idx    = '0;
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = HOLD_SLOTS - 1; i >= 0; i--) begin
            if (valid_q[i] && (key_q[i] == {w_ext, rx_data})) begin
                w_hit     = 1'b1;
                w_hit_idx = SLOT_W'(i);
            end
            if (!valid_q[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = SLOT_W'(i);
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        key_d   = key_q;
        if (w_ovf_rise) begin
            valid_d = '0;
        end else if (w_press && !w_hit && w_free_found) begin
            valid_d[w_free_idx] = 1'b1;
            key_d[w_free_idx]   = {w_ext, rx_data};
        end else if (w_release && w_hit) begin
            valid_d[w_hit_idx] = 1'b0;
        end
    end

    always_comb begin
        w_held_cnt = '0;
        for (int i = 0; i < HOLD_SLOTS; i++) begin
            w_held_cnt = w_held_cnt + HC_W'(valid_q[i]);
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            nextdata_n_q <= 1'b1;
            ovf_reg_q    <= 1'b0;
            ovf_prev_q   <= 1'b0;
            err_ovf_q    <= 1'b0;
            err_proto_q  <= 1'b0;
            ev_valid_q   <= 1'b0;
            ev_code_q    <= '0;
            ev_ext_q     <= 1'b0;
            ev_break_q   <= 1'b0;
            ev_repeat_q  <= 1'b0;
            disp_code_q  <= '0;
            disp_ext_q   <= 1'b0;
            press_cnt_q  <= '0;
            valid_q      <= '0;
            for (int i = 0; i < HOLD_SLOTS; i++) key_q[i] <= '0;
        end else begin
            nextdata_n_q <= ~w_take;
            ovf_reg_q    <= rx_overflow;
            ovf_prev_q   <= ovf_reg_q;
            err_ovf_q    <= err_ovf_q | w_ovf_rise;
            err_proto_q  <= w_proto;
            ev_valid_q   <= w_press | w_release;
            valid_q      <= valid_d;
            key_q        <= key_d;
            if (w_press || w_release) begin
                ev_code_q   <= rx_data;
                ev_ext_q    <= w_ext;
                ev_break_q  <= w_release;
                ev_repeat_q <= w_press & w_hit;
            end
            if (w_press && !w_hit) press_cnt_q <= press_cnt_q + 1'b1;
            if (w_ovf_rise || (w_release && w_hit && (valid_d == '0))) begin
                disp_code_q <= '0;
                disp_ext_q  <= 1'b0;
            end else if (w_press && !w_hit) begin
                disp_code_q <= rx_data;
                disp_ext_q  <= w_ext;
            end
        end
    end

    assign rx_nextdata_n = nextdata_n_q;
    assign ev_valid      = ev_valid_q;
    assign ev_code       = ev_code_q;
    assign ev_ext        = ev_ext_q;
    assign ev_break      = ev_break_q;
    assign ev_repeat     = ev_repeat_q;
    assign disp_code     = disp_code_q;
    assign disp_ext      = disp_ext_q;
    assign held_count    = w_held_cnt;
    assign any_held      = (w_held_cnt != '0);
    assign press_count   = press_cnt_q;
    assign err_overflow  = err_ovf_q;
    assign err_proto     = err_proto_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ps2_key_tracker : directed self-checking bench for ps2_key_tracker    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_ps2_key_tracker;

    localparam int HOLD_SLOTS = 4;
    localparam int CNT_W      = 8;
    localparam int HC_W       = $clog2(HOLD_SLOTS + 1);

    logic             clk = 1'b0;
    logic             clrn = 1'b0;
    logic             rx_ready = 1'b0;
    logic [7:0]       rx_data = 8'h00;
    logic             rx_overflow = 1'b0;
    logic             rx_nextdata_n;
    logic             ev_valid, ev_ext, ev_break, ev_repeat;
    logic [7:0]       ev_code, disp_code;
    logic             disp_ext, any_held, err_overflow, err_proto;
    logic [HC_W-1:0]  held_count;
    logic [CNT_W-1:0] press_count;

    int checks = 0;
    int errors = 0;

    logic       l_valid, l_ext, l_break, l_repeat, l_proto, l_pop, l_pop_after, l_valid_after;
    logic [7:0] l_code;

    ps2_key_tracker #(.HOLD_SLOTS(HOLD_SLOTS), .CNT_W(CNT_W)) dut (
        .clk(clk), .clrn(clrn), .rx_ready(rx_ready), .rx_data(rx_data),
        .rx_overflow(rx_overflow), .rx_nextdata_n(rx_nextdata_n),
        .ev_valid(ev_valid), .ev_code(ev_code), .ev_ext(ev_ext),
        .ev_break(ev_break), .ev_repeat(ev_repeat), .disp_code(disp_code),
        .disp_ext(disp_ext), .held_count(held_count), .any_held(any_held),
        .press_count(press_count), .err_overflow(err_overflow), .err_proto(err_proto)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one byte for a single take cycle and capture the T+1 outputs.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_ready = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
        l_valid  = ev_valid;
        l_code   = ev_code;
        l_ext    = ev_ext;
        l_break  = ev_break;
        l_repeat = ev_repeat;
        l_proto  = err_proto;
        l_pop    = rx_nextdata_n;
        @(posedge clk);
        #1;
        l_pop_after   = rx_nextdata_n;
        l_valid_after = ev_valid;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_nextdata_n", rx_nextdata_n, 1);
        check_eq("rst_ev_valid",   ev_valid, 0);
        check_eq("rst_disp_code",  disp_code, 0);
        check_eq("rst_held",       held_count, 0);
        check_eq("rst_press_cnt",  press_count, 0);
        check_eq("rst_err_ovf",    err_overflow, 0);
        check_eq("rst_err_proto",  err_proto, 0);
        @(negedge clk);
        clrn = 1'b1;

        // Plain press/release
        send(8'h1C);
        check_eq("p1_valid", l_valid, 1);
        check_eq("p1_code",  l_code, 8'h1C);
        check_eq("p1_ext",   l_ext, 0);
        check_eq("p1_break", l_break, 0);
        check_eq("p1_pop",   l_pop, 0);
        check_eq("p1_pop_release", l_pop_after, 1);
        check_eq("p1_pulse_one_cycle", l_valid_after, 0);
        check_eq("p1_press_cnt", press_count, 1);
        check_eq("p1_disp",  disp_code, 8'h1C);
        check_eq("p1_held",  held_count, 1);
        check_eq("p1_any",   any_held, 1);
        send(8'hF0);
        check_eq("f0_no_event", l_valid, 0);
        check_eq("f0_pop", l_pop, 0);
        send(8'h1C);
        check_eq("r1_valid", l_valid, 1);
        check_eq("r1_break", l_break, 1);
        check_eq("r1_code",  l_code, 8'h1C);
        check_eq("r1_held",  held_count, 0);
        check_eq("r1_disp",  disp_code, 0);

        // Extended key
        send(8'hE0);
        check_eq("e0_no_event", l_valid, 0);
        send(8'h75);
        check_eq("x_valid", l_valid, 1);
        check_eq("x_code",  l_code, 8'h75);
        check_eq("x_ext",   l_ext, 1);
        check_eq("x_disp_ext", disp_ext, 1);
        check_eq("x_disp",  disp_code, 8'h75);
        send(8'hE0);
        send(8'hF0);
        check_eq("xf0_pop", l_pop, 0);
        send(8'h75);
        check_eq("xr_valid", l_valid, 1);
        check_eq("xr_ext",   l_ext, 1);
        check_eq("xr_break", l_break, 1);
        check_eq("xr_disp_ext", disp_ext, 0);
        check_eq("xr_held",  held_count, 0);

        // Typematic repeats
        send(8'h1C);
        check_eq("t1_repeat", l_repeat, 0);
        send(8'h1C);
        check_eq("t2_valid",  l_valid, 1);
        check_eq("t2_repeat", l_repeat, 1);
        send(8'h1C);
        check_eq("t3_repeat", l_repeat, 1);
        send(8'hF0);
        send(8'h1C);
        check_eq("t_press_cnt", press_count, 3);
        check_eq("t_held", held_count, 0);

        // Slot saturation
        send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C);
        check_eq("s_press_cnt", press_count, 8);
        check_eq("s_held", held_count, 4);
        check_eq("s_disp", disp_code, 8'h2C);
        send(8'hF0); send(8'h2C);
        check_eq("s_untracked_rel_valid", l_valid, 1);
        check_eq("s_untracked_rel_held", held_count, 4);
        send(8'hF0); send(8'h15);
        check_eq("s_rel15_held", held_count, 3);
        check_eq("s_rel15_disp", disp_code, 8'h2C);
        send(8'hF0); send(8'h1D);
        send(8'hF0); send(8'h24);
        send(8'hF0); send(8'h2D);
        check_eq("s_all_rel_held", held_count, 0);
        check_eq("s_all_rel_disp", disp_code, 0);
        check_eq("s_all_rel_any", any_held, 0);

        // Protocol error
        send(8'hF0);
        send(8'hE0);
        check_eq("pe_pulse", l_proto, 1);
        check_eq("pe_no_event", l_valid, 0);
        check_eq("pe_one_cycle", err_proto, 0);
        send(8'h1C);
        check_eq("pe_next_valid", l_valid, 1);
        check_eq("pe_next_break", l_break, 0);
        check_eq("pe_next_ext", l_ext, 0);
        check_eq("pe_next_cnt", press_count, 9);

        // Overflow with two keys held
        send(8'h1D);
        check_eq("o_held_before", held_count, 2);
        @(negedge clk);
        rx_overflow = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_eq("o_err", err_overflow, 1);
        check_eq("o_held", held_count, 0);
        check_eq("o_disp", disp_code, 0);
        @(negedge clk);
        rx_overflow = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("o_sticky", err_overflow, 1);
        @(negedge clk);
        clrn = 1'b0;
        #1;
        check_eq("o_rst_err", err_overflow, 0);
        check_eq("o_rst_cnt", press_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
